crc32_frame_arb: RTL and testbench

Shares one CRC-32 engine between NUM_REQ requesters, each streaming 32-bit word frames.
- Round-robin arbitration at frame boundaries; the grant is held for the whole frame.
- Seeds the CRC register at frame start and folds in one word per accepted beat.
- Presents the final CRC, word count and requester ID on a valid/ready result port.
- Sits between the packet-ingest clients and the status/CSR logic that consumes frame checksums.

---
 rtl/crc32_arb_pkg.sv | 30 +++
 rtl/crc32.sv | 20 ++
 rtl/crc32_frame_arb.sv | 102 ++++++++++
 tb/tb_crc32_frame_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_arb_pkg.sv
// Shared types, default constants and round-robin helpers for the CRC-32 frame arbiter.
package crc32_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] DEF_SEED      = 32'h0000_0000;
  localparam logic [31:0] DEF_FINAL_XOR = 32'h0000_0000;
  localparam int          MAX_REQ       = 8;

  // First set bit of valid scanning upward from ptr and wrapping at n; returns ptr if none is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && k < n && valid[idx[2:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic int rr_inc(input int idx, input int n);
    rr_inc = (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/crc32.sv
// Combinational CRC-32 update (poly 04C11DB7, MSB first, no reflection) over one 32-bit word.
module crc32 (
  input  logic [31:0] crcIn,
  input  logic [31:0] data,
  output logic [31:0] crcOut
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] acc;

  always_comb begin
    acc = crcIn;
    for (int i = 31; i >= 0; i--) begin
      acc = {acc[30:0], 1'b0} ^ ((acc[31] ^ data[i]) ? POLY : 32'h0);
    end
    crcOut = acc;
  end

endmodule

// File: rtl/crc32_frame_arb.sv
// Round-robin frame arbiter sharing one CRC-32 engine; grant held for a whole frame,
// result offered on a valid/ready port.
module crc32_frame_arb
  import crc32_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] SEED      = DEF_SEED,
  parameter logic [31:0] FINAL_XOR = DEF_FINAL_XOR,
  parameter int          CNT_W     = 16,
  localparam int         ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  Clk,
  input  logic                  ARst,
  input  logic [NUM_REQ-1:0]    ReqValid,
  input  logic [32*NUM_REQ-1:0] ReqData,
  input  logic [NUM_REQ-1:0]    ReqLast,
  output logic [NUM_REQ-1:0]    ReqReady,
  output logic                  ResValid,
  input  logic                  ResReady,
  output logic [31:0]           ResCrc,
  output logic [CNT_W-1:0]      ResWords,
  output logic [ID_W-1:0]       ResId,
  output logic                  Busy
);

  state_t             state_reg, state_next;
  logic [31:0]        crc_reg;
  logic [31:0]        crc_upd;
  logic [CNT_W-1:0]   count_reg;
  logic [ID_W-1:0]    grant_reg;
  logic [ID_W-1:0]    rr_reg;
  logic [ID_W-1:0]    pick;
  logic [MAX_REQ-1:0] valid_pad;
  logic [31:0]        beat_data;
  logic               any_valid;
  logic               beat;
  logic               last_beat;

  assign valid_pad = MAX_REQ'(ReqValid);
  assign any_valid = |ReqValid;
  assign pick      = ID_W'(rr_pick(valid_pad, int'(rr_reg), NUM_REQ));
  assign beat_data = ReqData[32*grant_reg +: 32];
  assign beat      = (state_reg == RUN) && ReqValid[grant_reg];
  assign last_beat = beat && ReqLast[grant_reg];

  crc32 u_crc (
    .crcIn  (crc_reg),
    .data   (beat_data),
    .crcOut (crc_upd)
  );

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = RUN;
      RUN:     if (last_beat) state_next = DONE;
      DONE:    if (ResReady)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ReqReady = '0;
    if (state_reg == RUN) ReqReady[grant_reg] = 1'b1;
    ResValid = (state_reg == DONE);
    Busy     = (state_reg != IDLE);
  end

  // FINAL_XOR lives only on the output path; crc_reg always holds the raw remainder.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      crc_reg   <= SEED;
      count_reg <= '0;
      grant_reg <= '0;
      rr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (any_valid) begin
          grant_reg <= pick;
          crc_reg   <= SEED;
          count_reg <= '0;
        end
        RUN: if (beat) begin
          crc_reg   <= crc_upd;
          count_reg <= (&count_reg) ? count_reg : count_reg + 1'b1;
        end
        DONE: if (ResReady) rr_reg <= ID_W'(rr_inc(int'(grant_reg), NUM_REQ));
        default: ;
      endcase
    end
  end

  assign ResCrc   = crc_reg ^ FINAL_XOR;
  assign ResWords = count_reg;
  assign ResId    = grant_reg;

endmodule

// File: tb/tb_crc32_frame_arb.sv
// Directed self-checking bench for crc32_frame_arb: default instance plus a CNT_W=4 instance
// with non-zero seed and final XOR.
module tb_crc32_frame_arb;

  localparam logic [31:0] POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] S_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] S_FX   = 32'h0F0F_0F0F;
  localparam int          BOUND  = 400;

  logic        clk, arst;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [63:0] req_data;
  logic        res_valid, res_ready, busy;
  logic [31:0] res_crc;
  logic [15:0] res_words;
  logic [0:0]  res_id;

  logic [1:0]  s_valid, s_last, s_ready;
  logic [63:0] s_data;
  logic        s_res_valid, s_res_ready, s_busy;
  logic [31:0] s_res_crc;
  logic [3:0]  s_res_words;
  logic [0:0]  s_res_id;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] fw [0:11][0:31];
  int          flen [0:11];

  crc32_frame_arb #(.NUM_REQ(2)) u_dut (
    .Clk(clk), .ARst(arst), .ReqValid(req_valid), .ReqData(req_data), .ReqLast(req_last),
    .ReqReady(req_ready), .ResValid(res_valid), .ResReady(res_ready), .ResCrc(res_crc),
    .ResWords(res_words), .ResId(res_id), .Busy(busy)
  );

  crc32_frame_arb #(.NUM_REQ(2), .SEED(S_SEED), .FINAL_XOR(S_FX), .CNT_W(4)) u_sat (
    .Clk(clk), .ARst(arst), .ReqValid(s_valid), .ReqData(s_data), .ReqLast(s_last),
    .ReqReady(s_ready), .ResValid(s_res_valid), .ResReady(s_res_ready), .ResCrc(s_res_crc),
    .ResWords(s_res_words), .ResId(s_res_id), .Busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no response within %0d cycles", tag, BOUND);
  endtask

  // Reference: XOR the word into the register, then shift 32 times.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] frame_crc(input int f, input logic [31:0] seed);
    logic [31:0] c;
    c = seed;
    for (int k = 0; k < flen[f]; k++) c = crc_step(c, fw[f][k]);
    return c;
  endfunction

  task automatic do_reset();
    arst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic stream(input int id, input int f, input int gap, output int first_wait);
    int   waited;
    logic acc;
    first_wait = 0;
    for (int k = 0; k < flen[f]; k++) begin
      if (gap > 0 && k > 0) begin
        req_valid[id] = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check($sformatf("gap_ready_w%0d", k), 32'(req_ready[id]), 32'd1);
        end
      end
      req_valid[id] = 1'b1;
      req_data[32*id +: 32] = fw[f][k];
      req_last[id] = (k == flen[f] - 1);
      for (waited = 0; waited < BOUND; waited++) begin
        acc = req_ready[id];
        @(negedge clk);
        if (acc) break;
      end
      if (waited == BOUND) begin
        timeout($sformatf("accept_f%0d_w%0d", f, k));
        break;
      end
      if (k == 0) first_wait = waited;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic collect(input int f, input int exp_id, input int hold);
    int          waited;
    logic [31:0] exp_crc;
    exp_crc = frame_crc(f, 32'h0);
    for (waited = 0; waited < BOUND && !res_valid; waited++) @(negedge clk);
    if (!res_valid) begin
      timeout($sformatf("result_f%0d", f));
      return;
    end
    check($sformatf("id_f%0d", f), 32'(res_id), 32'(exp_id));
    check($sformatf("crc_f%0d", f), res_crc, exp_crc);
    check($sformatf("words_f%0d", f), 32'(res_words), 32'(flen[f]));
    $display("frame %0d: id=%0d words=%0d crc=%h", f, res_id, res_words, res_crc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_crc", res_crc, exp_crc);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check($sformatf("drop_f%0d", f), 32'(res_valid), 32'd0);
  endtask

  initial begin
    int w, wa, wb;
    logic acc;
    int waited;
    arst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b0;
    s_valid = '0; s_last = '0; s_data = '0; s_res_ready = 1'b0;

    flen[0] = 1;  fw[0][0] = 32'h0;
    flen[1] = 1;  fw[1][0] = 32'h1;
    flen[2] = 3;  fw[2][0] = 32'hDEAD_BEEF; fw[2][1] = 32'h1234_5678; fw[2][2] = 32'hCAFE_F00D;
    flen[3] = 2;  fw[3][0] = 32'hA5A5_0001; fw[3][1] = 32'h5A5A_0002;
    flen[4] = 1;  fw[4][0] = 32'h0BAD_F00D;
    flen[5] = 3;  fw[5][0] = 32'h1111_1111; fw[5][1] = 32'h2222_2222; fw[5][2] = 32'h3333_3333;
    flen[6] = 2;  fw[6][0] = 32'hFFFF_FFFF; fw[6][1] = 32'h8000_0000;
    flen[7] = 2;  fw[7][0] = 32'h0000_00FF; fw[7][1] = 32'hFF00_0000;
    flen[8] = 1;  fw[8][0] = 32'h7654_3210;
    flen[9] = 4;  fw[9][0] = 32'h1; fw[9][1] = 32'h2; fw[9][2] = 32'h3; fw[9][3] = 32'h4;
    flen[10] = 3; fw[10][0] = 32'hC001_D00D; fw[10][1] = 32'h0; fw[10][2] = 32'hFEED_FACE;
    flen[11] = 20;
    for (int k = 0; k < 20; k++) fw[11][k] = 32'(k) * 32'h0101_0101 + 32'h7;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_crc", res_crc, 32'h0);
    check("rst_sat_crc", s_res_crc, 32'hF0F0_F0F0);
    check("rst_words", 32'(res_words), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    arst = 1'b0;

    // single zero word with zero seed
    stream(0, 0, 0, w);
    check("first_beat_latency", 32'(w), 32'd1);
    check("resvalid_latency", 32'(res_valid), 32'd1);
    collect(0, 0, 0);

    // data word 1 leaves x^32 mod P = the polynomial itself
    stream(0, 1, 0, w);
    check("crc_hand_poly", res_crc, 32'h04C1_1DB7);
    collect(1, 0, 0);

    // three words with idle gaps between beats
    stream(0, 2, 2, w);
    collect(2, 0, 0);

    // alternation 0,1,0,1 from a fresh pointer
    do_reset();
    fork
      begin stream(0, 3, 0, wa); stream(0, 5, 0, wa); end
      begin stream(1, 4, 0, wb); stream(1, 6, 0, wb); end
      begin collect(3, 0, 0); collect(4, 1, 0); collect(5, 0, 0); collect(6, 1, 0); end
    join

    // result held 5 cycles with req1 pending
    fork
      stream(0, 7, 0, wa);
      stream(1, 8, 0, wb);
      begin collect(7, 0, 5); collect(8, 1, 0); end
    join

    // reset during the second word of a four-word frame
    req_valid[0] = 1'b1; req_data[31:0] = fw[9][0]; req_last[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_data[31:0] = fw[9][1];
    check("pre_arst_busy", 32'(busy), 32'd1);
    check("pre_arst_ready", 32'(req_ready), 32'd1);
    #2 arst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_crc", res_crc, 32'h0);
    check("arst_words", 32'(res_words), 32'd0);
    check("arst_id", 32'(res_id), 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    stream(1, 10, 0, w);
    collect(10, 1, 0);

    // saturating counter instance, 20 words
    s_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data[31:0] = fw[11][k];
      s_last[0] = (k == 19);
      for (waited = 0; waited < BOUND; waited++) begin
        acc = s_ready[0];
        @(negedge clk);
        if (acc) break;
      end
      if (waited == BOUND) begin
        timeout("sat_accept");
        break;
      end
    end
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    for (waited = 0; waited < BOUND && !s_res_valid; waited++) @(negedge clk);
    check("sat_valid", 32'(s_res_valid), 32'd1);
    check("sat_words", 32'(s_res_words), 32'd15);
    check("sat_crc", s_res_crc, frame_crc(11, S_SEED) ^ S_FX);
    check("sat_id", 32'(s_res_id), 32'd0);
    $display("frame 11 (sat): id=%0d words=%0d crc=%h", s_res_id, s_res_words, s_res_crc);
    s_res_ready = 1'b1;
    @(negedge clk);
    s_res_ready = 1'b0;
    check("sat_drop", 32'(s_res_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
